// File: rtl/simple_cnn_pkg.sv
// Shared constants and types for the CNN image-side feeder.
// Contents:
//   IMG_W, K, PIX_W        image side, kernel side, pixel width
//   CONV_W, NWIN           windows per row/column and total window count
//   CLASS_W                width of the CNN class index
//   WIN_W, NPIX            packed window width, pixels per image
//   TIMEOUT_CYCLES         WAIT_DONE budget (only used with FEEDER_TIMEOUT_EN)
//   feeder_state_t         feeder FSM states
package simple_cnn_pkg;

  localparam int IMG_W          = 28;
  localparam int K              = 5;
  localparam int PIX_W          = 8;
  localparam int CONV_W         = IMG_W - K + 1;
  localparam int NWIN           = CONV_W * CONV_W;
  localparam int CLASS_W        = 4;
  localparam int WIN_W          = K * K * PIX_W;
  localparam int NPIX           = IMG_W * IMG_W;
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SWEEP     = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/cnn_win_extract.sv
// Combinational KxK window extractor.
// Ports:
//   img  in   IMG_W x IMG_W array of PIX_W-bit pixels
//   row  in   window top row (0..CONV_W-1)
//   col  in   window left column (0..CONV_W-1)
//   win  out  packed window; pixel (i,j) at bits [(i*K+j)*PIX_W +: PIX_W]
module cnn_win_extract
  import simple_cnn_pkg::*;
(
  input  logic [PIX_W-1:0] img [IMG_W][IMG_W],
  input  logic [4:0]       row,
  input  logic [4:0]       col,
  output logic [WIN_W-1:0] win
);

  // Gather the KxK pixels anchored at (row, col).
  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[(i*K+j)*PIX_W +: PIX_W] = img[row + 5'(i)][col + 5'(j)];
      end
    end
  end

endmodule

// File: rtl/cnn_window_feeder.sv
// Image-side driver of the CNN classifier. Holds one IMG_W x IMG_W image,
// streams every KxK window to the CNN on GO, then captures the class index.
// Optional feature macro: FEEDER_TIMEOUT_EN (WAIT_DONE timeout with sticky ERR).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   PIX_WE/ADDR/DATA    image write port (IDLE only, addresses >= NPIX dropped)
//   GO                  start a classification (IDLE only)
//   BUSY                high in SWEEP and WAIT_DONE
//   CNN_START/X/Y/IMGIN window stream toward the CNN
//   CNN_DONE/CNN_OUT    completion pulse and class from the CNN
//   RESULT/RESULT_VALID captured class, valid until the next accepted GO
//   ERR                 timeout flag (constant 0 without FEEDER_TIMEOUT_EN)
module cnn_window_feeder
  import simple_cnn_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               PIX_WE,
  input  logic [9:0]         PIX_ADDR,
  input  logic [PIX_W-1:0]   PIX_DATA,
  input  logic               GO,
  output logic               BUSY,
  output logic               CNN_START,
  output logic [4:0]         CNN_X,
  output logic [4:0]         CNN_Y,
  output logic [WIN_W-1:0]   CNN_IMGIN,
  input  logic               CNN_DONE,
  input  logic [CLASS_W-1:0] CNN_OUT,
  output logic [CLASS_W-1:0] RESULT,
  output logic               RESULT_VALID,
  output logic               ERR
);

  logic [PIX_W-1:0] img [IMG_W][IMG_W];
  feeder_state_t    state;
  logic [9:0]       step;      // sweep output cycle currently on the outputs
  logic [4:0]       win_row;   // coordinates of the window now on CNN_IMGIN
  logic [4:0]       win_col;
  logic [4:0]       nxt_row;
  logic [4:0]       nxt_col;
  logic [4:0]       sel_row;
  logic [4:0]       sel_col;
  logic [4:0]       wr_row;
  logic [4:0]       wr_col;
  logic             write_ok;
  logic [WIN_W-1:0] ext_win;
  logic [WIN_W-1:0] fwd_win;

  assign wr_row   = 5'(PIX_ADDR / 10'd28);
  assign wr_col   = 5'(PIX_ADDR % 10'd28);
  assign write_ok = PIX_WE && (state == IDLE) && (PIX_ADDR < 10'(NPIX));

  // Image memory; not reset so the image survives RST.
  always_ff @(posedge CLK) begin
    if (write_ok) begin
      img[wr_row][wr_col] <= PIX_DATA;
    end
  end

  // Raster advance to the next window; wraps to (0,0) after the last one so
  // the extractor is never addressed past the image edge.
  always_comb begin
    nxt_row = win_row;
    nxt_col = win_col;
    if (win_col == 5'(CONV_W - 1)) begin
      nxt_col = 5'd0;
      if (win_row == 5'(CONV_W - 1)) begin
        nxt_row = 5'd0;
      end else begin
        nxt_row = win_row + 5'd1;
      end
    end else begin
      nxt_col = win_col + 5'd1;
    end
  end

  // In IDLE the window about to be loaded is always win(0).
  always_comb begin
    if (state == SWEEP) begin
      sel_row = nxt_row;
      sel_col = nxt_col;
    end else begin
      sel_row = 5'd0;
      sel_col = 5'd0;
    end
  end

  cnn_win_extract u_extract (
    .img (img),
    .row (sel_row),
    .col (sel_col),
    .win (ext_win)
  );

  // Forward a same-cycle pixel write into the window being loaded, so a
  // write issued together with GO shows up in win(0).
  always_comb begin
    fwd_win = ext_win;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (write_ok && (wr_row == sel_row + 5'(i)) && (wr_col == sel_col + 5'(j))) begin
          fwd_win[(i*K+j)*PIX_W +: PIX_W] = PIX_DATA;
        end else begin
          fwd_win[(i*K+j)*PIX_W +: PIX_W] = ext_win[(i*K+j)*PIX_W +: PIX_W];
        end
      end
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  logic [6:0] wait_cnt;
`else
  assign ERR = 1'b0;
`endif

  // Feeder FSM and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      BUSY         <= 1'b0;
      CNN_START    <= 1'b0;
      CNN_X        <= 5'd0;
      CNN_Y        <= 5'd0;
      CNN_IMGIN    <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      step         <= 10'd0;
      win_row      <= 5'd0;
      win_col      <= 5'd0;
`ifdef FEEDER_TIMEOUT_EN
      ERR          <= 1'b0;
      wait_cnt     <= 7'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (GO) begin
            state        <= SWEEP;
            BUSY         <= 1'b1;
            CNN_START    <= 1'b1;
            CNN_X        <= 5'd0;
            CNN_Y        <= 5'd0;
            CNN_IMGIN    <= fwd_win;
            RESULT_VALID <= 1'b0;
            step         <= 10'd0;
            win_row      <= 5'd0;
            win_col      <= 5'd0;
`ifdef FEEDER_TIMEOUT_EN
            ERR          <= 1'b0;
`endif
          end
        end
        SWEEP: begin
          CNN_START <= 1'b0;
          if (step == 10'(NWIN)) begin
            state     <= WAIT_DONE;
            CNN_IMGIN <= '0;
`ifdef FEEDER_TIMEOUT_EN
            wait_cnt  <= 7'd0;
`endif
          end else begin
            // X/Y lag IMGIN by one step: they label the window the CNN
            // latched on the previous cycle.
            CNN_X   <= win_row;
            CNN_Y   <= win_col;
            win_row <= nxt_row;
            win_col <= nxt_col;
            step    <= step + 10'd1;
            if (step == 10'(NWIN - 1)) begin
              CNN_IMGIN <= '0;
            end else begin
              CNN_IMGIN <= fwd_win;
            end
          end
        end
        WAIT_DONE: begin
          if (CNN_DONE) begin
            RESULT       <= CNN_OUT;
            RESULT_VALID <= 1'b1;
            BUSY         <= 1'b0;
            state        <= IDLE;
          end else begin
`ifdef FEEDER_TIMEOUT_EN
            if (wait_cnt == 7'(TIMEOUT_CYCLES - 1)) begin
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 7'd1;
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Directed self-checking bench for cnn_window_feeder.
module tb_cnn_window_feeder;

  logic         CLK = 1'b0;
  logic         RST;
  logic         PIX_WE;
  logic [9:0]   PIX_ADDR;
  logic [7:0]   PIX_DATA;
  logic         GO;
  logic         BUSY;
  logic         CNN_START;
  logic [4:0]   CNN_X;
  logic [4:0]   CNN_Y;
  logic [199:0] CNN_IMGIN;
  logic         CNN_DONE;
  logic [3:0]   CNN_OUT;
  logic [3:0]   RESULT;
  logic         RESULT_VALID;
  logic         ERR;

  logic [7:0]   ref_img [784];
  int           ncmp = 0;
  int           nfail = 0;

  cnn_window_feeder dut (
    .CLK          (CLK),
    .RST          (RST),
    .PIX_WE       (PIX_WE),
    .PIX_ADDR     (PIX_ADDR),
    .PIX_DATA     (PIX_DATA),
    .GO           (GO),
    .BUSY         (BUSY),
    .CNN_START    (CNN_START),
    .CNN_X        (CNN_X),
    .CNN_Y        (CNN_Y),
    .CNN_IMGIN    (CNN_IMGIN),
    .CNN_DONE     (CNN_DONE),
    .CNN_OUT      (CNN_OUT),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .ERR          (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] win_model(input int r, input int c);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        w[(i*5+j)*8 +: 8] = ref_img[(r+i)*28 + c + j];
      end
    end
    return w;
  endfunction

  // Check output steps 0..last of a sweep; step 0 must already be visible.
  task automatic sweep(input int last, input bit hooks);
    logic [210:0] expv;
    for (int s = 0; s <= last; s++) begin
      if (s == 0) begin
        expv = {5'd0, 5'd0, 1'b1, win_model(0, 0)};
      end else if (s == 576) begin
        expv = {5'd23, 5'd23, 1'b0, 200'd0};
      end else begin
        expv = {5'((s-1)/24), 5'((s-1)%24), 1'b0, win_model(s/24, s%24)};
      end
      check($sformatf("stream_s%0d", s), 256'({CNN_X, CNN_Y, CNN_START, CNN_IMGIN}), 256'(expv));
      check($sformatf("busy_s%0d", s), 256'(BUSY), 256'(1'b1));
      if (s == 1) begin
        check("s1_xy", 256'({CNN_X, CNN_Y}), 256'(10'd0));
        check("s1_byte0", 256'(CNN_IMGIN[7:0]), 256'(8'd1));
      end
      if (s == 24) begin
        check("s24_xy", 256'({CNN_X, CNN_Y}), 256'({5'd0, 5'd23}));
        check("s24_byte0", 256'(CNN_IMGIN[7:0]), 256'(8'd28));
      end
      if (s == 576) begin
        check("s576_xy", 256'({CNN_X, CNN_Y}), 256'({5'd23, 5'd23}));
        check("s576_imgin", 256'(CNN_IMGIN), 256'(0));
      end
      if (hooks && s == 10) begin
        PIX_WE = 1'b1; PIX_ADDR = 10'd0; PIX_DATA = 8'h55;
      end
      if (hooks && s == 11) begin
        PIX_WE = 1'b0;
      end
      if (hooks && s == 100) begin
        CNN_DONE = 1'b1; CNN_OUT = 4'd3;
      end
      if (hooks && s == 101) begin
        CNN_DONE = 1'b0;
      end
      if (s < last) tick();
    end
  endtask

  initial begin
    int n;
    RST = 1'b1; PIX_WE = 1'b0; PIX_ADDR = 10'd0; PIX_DATA = 8'd0;
    GO = 1'b0; CNN_DONE = 1'b0; CNN_OUT = 4'd0;
    tick(); tick();
    check("rst_busy", 256'(BUSY), 256'(1'b0));
    check("rst_start", 256'(CNN_START), 256'(1'b0));
    check("rst_xy", 256'({CNN_X, CNN_Y}), 256'(10'd0));
    check("rst_imgin", 256'(CNN_IMGIN), 256'(0));
    check("rst_result", 256'({RESULT, RESULT_VALID, ERR}), 256'(6'd0));
    RST = 1'b0;

    // Ramp image
    for (int a = 0; a < 784; a++) begin
      PIX_WE = 1'b1; PIX_ADDR = 10'(a); PIX_DATA = 8'(a);
      ref_img[a] = 8'(a);
      tick();
    end
    PIX_WE = 1'b0;

    // Run 1: full sweep, dropped write at s=10, stray DONE at s=100
    GO = 1'b1; tick(); GO = 1'b0;
    check("s0_start", 256'(CNN_START), 256'(1'b1));
    check("s0_byte0", 256'(CNN_IMGIN[7:0]), 256'(8'd0));
    check("s0_byte24", 256'(CNN_IMGIN[199:192]), 256'(8'd116));
    sweep(576, 1'b1);
    tick();
    check("wait_busy", 256'(BUSY), 256'(1'b1));
    check("wait_start", 256'(CNN_START), 256'(1'b0));
    check("stray_done_ignored", 256'(RESULT_VALID), 256'(1'b0));
    tick(); tick(); tick();
    check("wait_busy_hold", 256'(BUSY), 256'(1'b1));
    CNN_DONE = 1'b1; CNN_OUT = 4'd7;
    tick();
    CNN_DONE = 1'b0;
    check("result", 256'(RESULT), 256'(4'd7));
    check("result_valid", 256'(RESULT_VALID), 256'(1'b1));
    check("done_busy", 256'(BUSY), 256'(1'b0));
    check("done_err", 256'(ERR), 256'(1'b0));

    // Run 2: GO clears RESULT_VALID; reset at s=300; restart
    GO = 1'b1; tick(); GO = 1'b0;
    check("go_clears_valid", 256'(RESULT_VALID), 256'(1'b0));
    sweep(300, 1'b0);
    RST = 1'b1; tick(); RST = 1'b0;
    check("midrst_outputs", 256'({BUSY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN, RESULT, RESULT_VALID, ERR}), 256'(0));
    GO = 1'b1; tick(); GO = 1'b0;
    check("dropped_write", 256'(CNN_IMGIN[7:0]), 256'(8'd0));
    sweep(576, 1'b0);
`ifdef FEEDER_TIMEOUT_EN
    n = 0;
    while (BUSY && n < 200) begin
      tick();
      n++;
    end
    check("timeout_steps", 256'(n), 256'(65));
    check("timeout_err", 256'(ERR), 256'(1'b1));
    check("timeout_valid", 256'(RESULT_VALID), 256'(1'b0));
    tick(); tick();
    check("err_sticky", 256'(ERR), 256'(1'b1));
    GO = 1'b1; tick(); GO = 1'b0;
    check("go_clears_err", 256'(ERR), 256'(1'b0));
    RST = 1'b1; tick(); RST = 1'b0;
`else
    n = 0;
    repeat (100) begin
      tick();
      n++;
    end
    check("no_timeout_busy", 256'(BUSY), 256'(1'b1));
    check("no_timeout_err", 256'(ERR), 256'(1'b0));
    CNN_DONE = 1'b1; CNN_OUT = 4'hC;
    tick();
    CNN_DONE = 1'b0;
    check("result2", 256'({RESULT, RESULT_VALID}), 256'({4'hC, 1'b1}));
`endif

    // Run 3: write together with GO lands in win(0)
    PIX_WE = 1'b1; PIX_ADDR = 10'd0; PIX_DATA = 8'hAA; GO = 1'b1;
    tick();
    PIX_WE = 1'b0; GO = 1'b0;
    ref_img[0] = 8'hAA;
    check("we_go_byte0", 256'(CNN_IMGIN[7:0]), 256'(8'hAA));
    sweep(30, 1'b0);
    RST = 1'b1; tick(); RST = 1'b0;
    check("final_idle", 256'(BUSY), 256'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
